traffic_control_n: RTL and testbench
====================================

# traffic_control_n

Parametrised N-approach traffic signal controller, the successor to the fixed four-way controller. It cycles green, yellow and all-red clearance around N_DIR approaches with programmable durations. It adds three features: demand-based skipping of idle approaches, emergency preemption, and a flashing-red failsafe mode. It drives the lamp drivers directly and takes sensor, preemption and mode inputs from the intersection I/O block.

## Interface
- N_DIR, 4: number of approaches, 2..16; DIR_W = $clog2(N_DIR)
- GREEN_CYC, 8: green duration in cycles, ≥1
- YELLOW_CYC, 4: yellow duration in cycles, ≥1
- CLEAR_CYC, 1: all-red clearance in cycles, ≥0 (0 = no clearance phase)
- FLASH_CYC, 2: flash half-period in cycles, ≥1
- clk  in  1  system clock, rising edge
- rst_a  in  1  asynchronous, active-low reset
- demand  in  N_DIR  vehicle sensor per approach, level or pulse
- skip_en  in  1  1 = skip approaches with no latched demand
- preempt_req  in  1  emergency request, level
- preempt_dir  in  DIR_W  approach to serve; stable while preempt_req=1
- flash  in  1  failsafe flash mode, level
- lights  out  3*N_DIR  approach i at [3i+2:3i]: 001 green, 010 yellow, 100 red, 000 dark
- cur_dir  out  DIR_W  approach currently owning green/yellow
- phase  out  2  0 GREEN, 1 YELLOW, 2 ALLRED, 3 FLASH
- pending  out  N_DIR  latched demand

## Operation
- One down-counter `cnt` is loaded with (duration−1) on phase entry and decrements each cycle. The phase ends on the cycle after cnt==0.
- GREEN: lights[cur_dir]=001, all other approaches 100. At cnt==0 → YELLOW.
- YELLOW: lights[cur_dir]=010, all others 100. At cnt==0 → ALLRED, or directly to the next GREEN if CLEAR_CYC=0.
- ALLRED: all approaches 100. At cnt==0 → GREEN of the selected next approach.
- Next-approach selection, evaluated at the end of clearance, in priority order:
  - preempt_req=1 → preempt_dir.
  - skip_en=1 and any pending bit set → first approach with pending set, searching round-robin from cur_dir+1 and wrapping at N_DIR−1→0. cur_dir itself is last in the search.
  - Otherwise → cur_dir+1, wrapping to 0.
- Demand latch:
  - pending[i] is set by demand[i]=1.
  - pending[i] is cleared on the edge where approach i enters GREEN. Clear wins over a simultaneous set.
- Preemption:
  - preempt_req=1 during GREEN with cur_dir≠preempt_dir → YELLOW on the next edge (green truncated).
  - preempt_req=1 during GREEN with cur_dir==preempt_dir → cnt holds and green is extended. After release, the remaining cnt runs out normally.
  - During YELLOW/ALLRED, preemption only affects selection; durations are never shortened.
  - After the preempted green, normal selection resumes from preempt_dir.
- Flash:
  - flash=1 → FLASH on the next edge from any phase. Flash has priority over preemption.
  - In FLASH, all approaches alternate 100 / 000, starting at 100, toggling every FLASH_CYC cycles. pending continues to latch.
  - flash=0 → ALLRED for CLEAR_CYC cycles, then GREEN of approach 0. If CLEAR_CYC=0, go directly to GREEN of approach 0.
- At most one approach is ever non-red. No phase produces two greens or a green→red transition without yellow, except on flash entry.

## Timing
- Reset (rst_a=0, asynchronous, also mid-operation) sets:
  - phase=GREEN, cur_dir=0, cnt=GREEN_CYC−1
  - pending=0, flash toggle=0
  - lights = approach 0 at 001, all others 100
- Outputs decode only registered state, with no combinational path from inputs. Every input takes effect on lights at the first rising edge at which it is sampled.
- Normal cycle period with no skipping = N_DIR·(GREEN_CYC+YELLOW_CYC+CLEAR_CYC) cycles.
- Preempt-to-green latency, worst case from the first cycle of a non-target green = 1 + YELLOW_CYC + CLEAR_CYC cycles.
- cnt width = $clog2(max(GREEN_CYC, YELLOW_CYC, CLEAR_CYC, FLASH_CYC)+1). cur_dir arithmetic wraps modulo N_DIR, not 2^DIR_W.

## Test plan
- Defaults, idle inputs:
  - After reset release, approach 0 green for 8 cycles, yellow for 4, all-red for 1, then approach 1 green.
  - Full rotation returns to approach 0 after 52 cycles.
- skip_en=1, single demand pulse on approach 2 during approach 0 green:
  - After approach 0 clearance, approach 2 goes green (approach 1 skipped).
  - pending[2] clears on that green entry edge.
- preempt_req=1, preempt_dir=3 on the 3rd green cycle of approach 0:
  - Yellow on the next edge, then 4 yellow, 1 all-red, then approach 3 green held while the request is high.
  - Release → 8 more green cycles, then yellow, then approach 0.
- flash=1 mid-yellow with FLASH_CYC=2:
  - phase=3 on the next edge; all lights follow 100,100,000,000,…
  - flash=0 → 1 all-red cycle, then approach 0 green.
- Reset asserted mid-green of approach 2 with pending nonzero:
  - Lights immediately show approach 0 at 001, others 100; pending=0.
- N_DIR=3, CLEAR_CYC=0:
  - Sequence 0→1→2→0, yellow goes directly to the next green, cur_dir never equals 3.

Source files
------------

// File: rtl/traffic_control_n.sv
// N-approach traffic signal controller: green/yellow/all-red rotation with demand skipping,
// emergency preemption and a flashing-red failsafe mode. All outputs come straight from flops.
module traffic_control_n #(
    parameter int N_DIR      = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 4,
    parameter int CLEAR_CYC  = 1,
    parameter int FLASH_CYC  = 2,
    parameter int DIR_W      = $clog2(N_DIR)
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic [N_DIR-1:0]     demand,
    input  logic                 skip_en,
    input  logic                 preempt_req,
    input  logic [DIR_W-1:0]     preempt_dir,
    input  logic                 flash,
    output logic [3*N_DIR-1:0]   lights,
    output logic [DIR_W-1:0]     cur_dir,
    output logic [1:0]           phase,
    output logic [N_DIR-1:0]     pending
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_FLASH  = 2'd3
    } phase_e;

    localparam int MAX_GY = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
    localparam int MAX_CF = (CLEAR_CYC > FLASH_CYC) ? CLEAR_CYC : FLASH_CYC;
    localparam int MAX_D  = (MAX_GY > MAX_CF) ? MAX_GY : MAX_CF;
    localparam int CNT_W  = $clog2(MAX_D + 1);

    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] F_LOAD = CNT_W'(FLASH_CYC - 1);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'((CLEAR_CYC > 0) ? CLEAR_CYC - 1 : 0);
    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(N_DIR - 1);

    function automatic logic [3*N_DIR-1:0] decode_lights(input phase_e ph,
                                                         input logic [DIR_W-1:0] dir,
                                                         input logic dark);
        logic [3*N_DIR-1:0] l;
        for (int i = 0; i < N_DIR; i++) begin
            if (ph == PH_FLASH)
                l[3*i +: 3] = dark ? 3'b000 : 3'b100;
            else if (ph == PH_GREEN && dir == DIR_W'(i))
                l[3*i +: 3] = 3'b001;
            else if (ph == PH_YELLOW && dir == DIR_W'(i))
                l[3*i +: 3] = 3'b010;
            else
                l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

    phase_e               phase_q, phase_d;
    logic [DIR_W-1:0]     cur_dir_q, cur_dir_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_DIR-1:0]     pending_q, pending_d;
    logic                 tog_q, tog_d;
    logic                 restart_q, restart_d;
    logic [3*N_DIR-1:0]   lights_q, lights_d;

    logic                 preempt_ok;
    logic [DIR_W-1:0]     inc_dir, rr_dir, green_dir;
    logic                 rr_found, enter_green;
    int                   idx;

    // Out-of-range preemption targets (non-power-of-two N_DIR) are ignored.
    assign preempt_ok = preempt_req && (int'(preempt_dir) < N_DIR);
    assign inc_dir    = (cur_dir_q == LAST_DIR) ? '0 : cur_dir_q + 1'b1;

    always_comb begin
        rr_found = 1'b0;
        rr_dir   = '0;
        idx      = 0;
        for (int k = 1; k <= N_DIR; k++) begin
            idx = int'(cur_dir_q) + k;
            if (idx >= N_DIR)
                idx = idx - N_DIR;
            if (!rr_found && pending_q[idx[DIR_W-1:0]]) begin
                rr_found = 1'b1;
                rr_dir   = idx[DIR_W-1:0];
            end
        end
    end

    // Leaving flash always restarts the rotation at approach 0.
    always_comb begin
        if (phase_q == PH_FLASH || restart_q)
            green_dir = '0;
        else if (preempt_ok)
            green_dir = preempt_dir;
        else if (skip_en && rr_found)
            green_dir = rr_dir;
        else
            green_dir = inc_dir;
    end

    always_comb begin
        phase_d     = phase_q;
        cur_dir_d   = cur_dir_q;
        cnt_d       = cnt_q;
        tog_d       = tog_q;
        restart_d   = restart_q;
        enter_green = 1'b0;

        if (flash) begin
            phase_d = PH_FLASH;
            if (phase_q != PH_FLASH) begin
                cnt_d = F_LOAD;
                tog_d = 1'b0;
            end else if (cnt_q == '0) begin
                cnt_d = F_LOAD;
                tog_d = ~tog_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (preempt_ok && preempt_dir != cur_dir_q) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = Y_LOAD;
                    end else if (preempt_ok) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == '0) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = Y_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (cnt_q == '0) begin
                        if (CLEAR_CYC > 0) begin
                            phase_d = PH_ALLRED;
                            cnt_d   = C_LOAD;
                        end else begin
                            enter_green = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PH_ALLRED: begin
                    if (cnt_q == '0)
                        enter_green = 1'b1;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                default: begin
                    restart_d = 1'b1;
                    if (CLEAR_CYC > 0) begin
                        phase_d = PH_ALLRED;
                        cnt_d   = C_LOAD;
                    end else begin
                        enter_green = 1'b1;
                    end
                end
            endcase
        end

        if (enter_green) begin
            phase_d   = PH_GREEN;
            cur_dir_d = green_dir;
            cnt_d     = G_LOAD;
            restart_d = 1'b0;
        end

        // The clear on green entry overrides a demand arriving on the same edge.
        pending_d = (pending_q | demand) &
                    ~(enter_green ? (N_DIR'(1) << green_dir) : {N_DIR{1'b0}});
        lights_d  = decode_lights(phase_d, cur_dir_d, tog_d);
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            phase_q   <= PH_GREEN;
            cur_dir_q <= '0;
            cnt_q     <= G_LOAD;
            pending_q <= '0;
            tog_q     <= 1'b0;
            restart_q <= 1'b0;
            lights_q  <= decode_lights(PH_GREEN, '0, 1'b0);
        end else begin
            phase_q   <= phase_d;
            cur_dir_q <= cur_dir_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tog_q     <= tog_d;
            restart_q <= restart_d;
            lights_q  <= lights_d;
        end
    end

    assign lights  = lights_q;
    assign cur_dir = cur_dir_q;
    assign phase   = phase_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_traffic_control_n.sv
// Scoreboard bench for traffic_control_n: a default 4-way instance and a 3-way instance
// without clearance, checked cycle by cycle against expected phase/direction/lights/pending.
module tb_traffic_control_n;

    localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2, F = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst2_a;
    logic [3:0]  demand;
    logic        skip_en, preempt_req, flash;
    logic [1:0]  preempt_dir;
    logic [11:0] lights;
    logic [1:0]  cur_dir, phase;
    logic [3:0]  pending;

    logic [2:0]  demand2;
    logic        skip2, preempt2, flash2;
    logic [1:0]  preempt_dir2;
    logic [8:0]  lights2;
    logic [1:0]  cur_dir2, phase2;
    logic [2:0]  pending2;

    traffic_control_n dut (
        .clk(clk), .rst_a(rst_a), .demand(demand), .skip_en(skip_en),
        .preempt_req(preempt_req), .preempt_dir(preempt_dir), .flash(flash),
        .lights(lights), .cur_dir(cur_dir), .phase(phase), .pending(pending)
    );

    traffic_control_n #(.N_DIR(3), .CLEAR_CYC(0)) dut3 (
        .clk(clk), .rst_a(rst2_a), .demand(demand2), .skip_en(skip2),
        .preempt_req(preempt2), .preempt_dir(preempt_dir2), .flash(flash2),
        .lights(lights2), .cur_dir(cur_dir2), .phase(phase2), .pending(pending2)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          unit;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (pend|phase|dir|lights)", tag, obs, exp);
        end
    endtask

    // Packs {pending[3:0], phase, cur_dir, lights[11:0]} for either instance.
    function automatic logic [31:0] build(input int u, input logic [1:0] ph, input logic [1:0] dir,
                                          input logic [3:0] pend, input logic dark);
        logic [11:0] l;
        int          n;
        n = (u == 1) ? 4 : 3;
        l = '0;
        for (int i = 0; i < n; i++) begin
            if (ph == F)                         l[3*i +: 3] = dark ? 3'b000 : 3'b100;
            else if (ph == G && dir == 2'(i))    l[3*i +: 3] = 3'b001;
            else if (ph == Y && dir == 2'(i))    l[3*i +: 3] = 3'b010;
            else                                 l[3*i +: 3] = 3'b100;
        end
        return {12'b0, pend, ph, dir, l};
    endfunction

    function automatic logic [31:0] observe(input int u);
        if (u == 1)
            return {12'b0, pending, phase, cur_dir, lights};
        else
            return {12'b0, 1'b0, pending2, phase2, cur_dir2, 3'b000, lights2};
    endfunction

    task automatic now_chk(input int u, input logic [1:0] ph, input logic [1:0] dir,
                           input logic [3:0] pend, input string tag);
        exp_t e;
        sb.push_back('{tag, u, build(u, ph, dir, pend, 1'b0)});
        e = sb.pop_front();
        check_val(e.tag, observe(e.unit), e.exp);
    endtask

    task automatic step(input int u, input logic [1:0] ph, input logic [1:0] dir,
                        input logic [3:0] pend, input logic dark, input string tag);
        exp_t e;
        sb.push_back('{tag, u, build(u, ph, dir, pend, dark)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val(e.tag, observe(e.unit), e.exp);
    endtask

    task automatic run(input int u, input logic [1:0] ph, input logic [1:0] dir,
                       input logic [3:0] pend, input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(u, ph, dir, pend, 1'b0, tag);
    endtask

    // Called 1 time unit after a rising edge; asserts reset mid-cycle.
    task automatic reset1();
        #2;
        rst_a       = 1'b0;
        demand      = '0;
        skip_en     = 1'b0;
        preempt_req = 1'b0;
        preempt_dir = '0;
        flash       = 1'b0;
        #1;
        now_chk(1, G, 2'd0, 4'b0000, "reset_state");
        @(posedge clk);
        #1;
        rst_a = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0; rst2_a = 1'b0;
        demand = '0; skip_en = 1'b0; preempt_req = 1'b0; preempt_dir = '0; flash = 1'b0;
        demand2 = '0; skip2 = 1'b0; preempt2 = 1'b0; preempt_dir2 = '0; flash2 = 1'b0;
        @(posedge clk);
        #1;

        // Idle rotation through all four approaches.
        reset1();
        run(1, G, 2'd0, 4'b0000, 7, "t1_green0");
        run(1, Y, 2'd0, 4'b0000, 4, "t1_yellow0");
        run(1, R, 2'd0, 4'b0000, 1, "t1_allred0");
        for (int d = 1; d < 4; d++) begin
            run(1, G, 2'(d), 4'b0000, 8, "t1_green");
            run(1, Y, 2'(d), 4'b0000, 4, "t1_yellow");
            run(1, R, 2'(d), 4'b0000, 1, "t1_allred");
        end
        step(1, G, 2'd0, 4'b0000, 1'b0, "t1_wrap0");

        // Demand skipping.
        reset1();
        skip_en = 1'b1;
        step(1, G, 2'd0, 4'b0000, 1'b0, "t2_green0");
        demand = 4'b0100;
        step(1, G, 2'd0, 4'b0100, 1'b0, "t2_latch");
        demand = 4'b0000;
        run(1, G, 2'd0, 4'b0100, 5, "t2_green0");
        run(1, Y, 2'd0, 4'b0100, 4, "t2_yellow0");
        run(1, R, 2'd0, 4'b0100, 1, "t2_allred0");
        step(1, G, 2'd2, 4'b0000, 1'b0, "t2_skip_to2");
        run(1, G, 2'd2, 4'b0000, 7, "t2_green2");
        run(1, Y, 2'd2, 4'b0000, 4, "t2_yellow2");
        run(1, R, 2'd2, 4'b0000, 1, "t2_allred2");
        step(1, G, 2'd3, 4'b0000, 1'b0, "t2_next3");

        // Preemption to approach 3 with extended green.
        reset1();
        run(1, G, 2'd0, 4'b0000, 2, "t3_green0");
        preempt_req = 1'b1;
        preempt_dir = 2'd3;
        run(1, Y, 2'd0, 4'b0000, 4, "t3_truncate");
        run(1, R, 2'd0, 4'b0000, 1, "t3_allred");
        run(1, G, 2'd3, 4'b0000, 5, "t3_hold3");
        preempt_req = 1'b0;
        run(1, G, 2'd3, 4'b0000, 7, "t3_release");
        run(1, Y, 2'd3, 4'b0000, 4, "t3_yellow3");
        run(1, R, 2'd3, 4'b0000, 1, "t3_allred3");
        step(1, G, 2'd0, 4'b0000, 1'b0, "t3_resume0");

        // Flash entered mid-yellow; pending keeps latching.
        reset1();
        run(1, G, 2'd0, 4'b0000, 7, "t4_green0");
        run(1, Y, 2'd0, 4'b0000, 2, "t4_yellow0");
        flash = 1'b1;
        step(1, F, 2'd0, 4'b0000, 1'b0, "t4_flash_on");
        step(1, F, 2'd0, 4'b0000, 1'b0, "t4_flash_on");
        demand = 4'b0010;
        step(1, F, 2'd0, 4'b0010, 1'b1, "t4_flash_dark");
        demand = 4'b0000;
        step(1, F, 2'd0, 4'b0010, 1'b1, "t4_flash_dark");
        step(1, F, 2'd0, 4'b0010, 1'b0, "t4_flash_on2");
        step(1, F, 2'd0, 4'b0010, 1'b0, "t4_flash_on2");
        flash = 1'b0;
        step(1, R, 2'd0, 4'b0010, 1'b0, "t4_exit_allred");
        step(1, G, 2'd0, 4'b0010, 1'b0, "t4_exit_green0");

        // Asynchronous reset in the middle of approach 2 green.
        reset1();
        skip_en = 1'b1;
        demand  = 4'b1100;
        step(1, G, 2'd0, 4'b1100, 1'b0, "t5_latch");
        demand = 4'b0000;
        run(1, G, 2'd0, 4'b1100, 6, "t5_green0");
        run(1, Y, 2'd0, 4'b1100, 4, "t5_yellow0");
        run(1, R, 2'd0, 4'b1100, 1, "t5_allred0");
        step(1, G, 2'd2, 4'b1000, 1'b0, "t5_green2");
        run(1, G, 2'd2, 4'b1000, 2, "t5_green2");
        reset1();
        step(1, G, 2'd0, 4'b0000, 1'b0, "t5_after_reset");

        // Three approaches, no clearance phase.
        now_chk(2, G, 2'd0, 4'b0000, "t6_reset_state");
        @(posedge clk);
        #1;
        rst2_a = 1'b1;
        run(2, G, 2'd0, 4'b0000, 7, "t6_green0");
        run(2, Y, 2'd0, 4'b0000, 4, "t6_yellow0");
        run(2, G, 2'd1, 4'b0000, 8, "t6_green1");
        run(2, Y, 2'd1, 4'b0000, 4, "t6_yellow1");
        run(2, G, 2'd2, 4'b0000, 8, "t6_green2");
        run(2, Y, 2'd2, 4'b0000, 4, "t6_yellow2");
        step(2, G, 2'd0, 4'b0000, 1'b0, "t6_wrap0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
